fib_result_checker: RTL and testbench

Self-checking result monitor for the MIPS processor simulation and FPGA bring-up flow. It waits for the processor to halt, or for a bounded run window to expire. It then walks a window of data-memory words through a synchronous read port and compares each word against a Fibonacci sequence it generates internally. It reports pass/fail, the mismatch count and the first failing word, replacing manual inspection of memory dumps and generalising that check in width, depth, window position and seeding mode.

---
 rtl/mips_check_pkg.sv | 28 ++
 rtl/fib_gen.sv | 52 +++++
 rtl/fib_result_checker.sv | 202 ++++++++++++++++++++
 tb/tb_fib_result_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_check_pkg.sv
// Shared types and width helpers for the Fibonacci result checker.
package mips_check_pkg;

  // Checker sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSeed0,
    StSeed1,
    StScan,
    StDrain,
    StDone
  } state_e;

  // What the read issued last cycle was for; tags the data arriving this cycle.
  typedef enum logic [1:0] {
    RdNone,
    RdSeed0,
    RdSeed1,
    RdScan
  } rd_kind_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fib_gen.sv
// Expected-value generator: a/b term registers with seed set, single-word
// loads and a wrap-around Fibonacci step.
module fib_gen #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic [DATA_W-1:0] set_a_i,
  input  logic [DATA_W-1:0] set_b_i,
  input  logic              load_a_i,
  input  logic              load_b_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              step_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  // Sum is naturally modulo 2**DATA_W.
  assign sum_o = a_q + b_q;

  // Next a/b: seed set wins, otherwise loads and step.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (set_i) begin
      a_d = set_a_i;
      b_d = set_b_i;
    end else begin
      if (load_a_i) a_d = load_data_i;
      if (load_b_i) b_d = load_data_i;
      if (step_i) begin
        a_d = b_q;
        b_d = sum_o;
      end
    end
  end

  // Term registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/fib_result_checker.sv
// Waits for halt (or a bounded run window), then scans a window of data memory
// and checks it against an internally generated Fibonacci sequence.
module fib_result_checker
  import mips_check_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_IDX  = 3,
  parameter int unsigned NUM_TERMS  = 10,
  parameter int unsigned RUN_CYCLES = 200,
  parameter int unsigned SEED_MODE  = 0,
  parameter int unsigned SEED0      = 1,
  parameter int unsigned SEED1      = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             halt_i,
  output logic                             rd_en_o,
  output logic [ADDR_W-1:0]                rd_addr_o,
  input  logic [DATA_W-1:0]                rd_data_i,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             timeout,
  output logic [$clog2(NUM_TERMS+1)-1:0]   mismatch_cnt,
  output logic [ADDR_W-1:0]                first_bad_idx,
  output logic [DATA_W-1:0]                first_bad_data
);

  localparam int unsigned CntW = cnt_width(NUM_TERMS);
  localparam int unsigned RunW = cnt_width(RUN_CYCLES);

  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] Seed0Addr = ADDR_W'(START_IDX - 2);
  localparam logic [ADDR_W-1:0] Seed1Addr = ADDR_W'(START_IDX - 1);
  localparam logic [RunW-1:0]   RunLast   = RunW'(RUN_CYCLES - 1);
  localparam logic [CntW-1:0]   KLast     = CntW'(NUM_TERMS - 1);

  // Reject parameter sets that cannot describe a valid window.
  if (NUM_TERMS < 1) begin : g_err_terms
    $error("fib_result_checker: NUM_TERMS must be at least 1");
  end
  if (((START_IDX + NUM_TERMS - 1) >> ADDR_W) != 0) begin : g_err_window
    $error("fib_result_checker: checked window exceeds address space");
  end
  if (SEED_MODE == 0 && START_IDX < 2) begin : g_err_seed
    $error("fib_result_checker: START_IDX must be >= 2 when seeds come from memory");
  end

  state_e            state_q, state_d;
  rd_kind_e          rd_kind_q, rd_kind_d;
  logic [RunW-1:0]   cyc_q, cyc_d;
  logic [CntW-1:0]   k_q, k_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] bad_idx_q, bad_idx_d;
  logic [DATA_W-1:0] bad_data_q, bad_data_d;

  logic              fib_set, fib_load_a, fib_load_b, fib_step;
  logic [DATA_W-1:0] fib_sum;

  fib_gen #(
    .DATA_W (DATA_W)
  ) u_fib_gen (
    .clk         (clk),
    .reset       (reset),
    .set_i       (fib_set),
    .set_a_i     (DATA_W'(SEED0)),
    .set_b_i     (DATA_W'(SEED1)),
    .load_a_i    (fib_load_a),
    .load_b_i    (fib_load_b),
    .load_data_i (rd_data_i),
    .step_i      (fib_step),
    .sum_o       (fib_sum)
  );

  // Read port: address per state, and tag for the data returning next cycle.
  always_comb begin
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    rd_kind_d = RdNone;
    unique case (state_q)
      StSeed0: begin
        rd_en_o   = 1'b1;
        rd_addr_o = Seed0Addr;
        rd_kind_d = RdSeed0;
      end
      StSeed1: begin
        rd_en_o   = 1'b1;
        rd_addr_o = Seed1Addr;
        rd_kind_d = RdSeed1;
      end
      StScan: begin
        rd_en_o   = 1'b1;
        rd_addr_o = StartAddr + ADDR_W'(k_q);
        rd_kind_d = RdScan;
      end
      default: ;
    endcase
  end

  // Address of the word whose data arrives next cycle.
  assign last_addr_d = rd_addr_o;

  // Sequencing plus handling of returned read data.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    bad_idx_d  = bad_idx_q;
    bad_data_d = bad_data_q;
    fib_set    = 1'b0;
    fib_load_a = 1'b0;
    fib_load_b = 1'b0;
    fib_step   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          cyc_d      = '0;
          k_d        = '0;
          cnt_d      = '0;
          timeout_d  = 1'b0;
          bad_idx_d  = '0;
          bad_data_d = '0;
          fib_set    = 1'b1;
        end
      end
      StRun: begin
        cyc_d = cyc_q + RunW'(1);
        if (halt_i || cyc_q == RunLast) begin
          // A halt on the last window cycle still counts as a clean halt.
          timeout_d = ~halt_i;
          state_d   = (SEED_MODE != 0) ? StScan : StSeed0;
        end
      end
      StSeed0: state_d = StSeed1;
      StSeed1: state_d = StScan;
      StScan: begin
        k_d = k_q + CntW'(1);
        if (k_q == KLast) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase

    unique case (rd_kind_q)
      RdSeed0: fib_load_a = 1'b1;
      RdSeed1: fib_load_b = 1'b1;
      RdScan: begin
        fib_step = 1'b1;
        if (rd_data_i != fib_sum) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == '0) begin
            bad_idx_d  = last_addr_q;
            bad_data_d = rd_data_i;
          end
        end
      end
      default: ;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_kind_q   <= RdNone;
      cyc_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      last_addr_q <= '0;
      bad_idx_q   <= '0;
      bad_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_kind_q   <= rd_kind_d;
      cyc_q       <= cyc_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      last_addr_q <= last_addr_d;
      bad_idx_q   <= bad_idx_d;
      bad_data_q  <= bad_data_d;
    end
  end

  assign done           = (state_q == StDone);
  assign busy           = (state_q != StIdle) && (state_q != StDone);
  assign pass           = done && (cnt_q == '0);
  assign timeout        = timeout_q;
  assign mismatch_cnt   = cnt_q;
  assign first_bad_idx  = bad_idx_q;
  assign first_bad_data = bad_data_q;

endmodule

// File: tb/tb_fib_result_checker.sv
// Bench for fib_result_checker: three instances (default, 8-bit/one-term/short
// window, fixed seeds) against bench-side memories and a sequence model.
module tb_fib_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_v  [3];
  logic        halt_v   [3];
  wire         rd_en_v  [3];
  wire  [7:0]  addr_v   [3];
  logic [31:0] rd_data_v[3];
  wire         busy_v   [3];
  wire         done_v   [3];
  wire         pass_v   [3];
  wire         tmo_v    [3];
  wire  [7:0]  bidx_v   [3];
  wire  [3:0]  cnt_a, cnt_c;
  wire  [0:0]  cnt_b;
  wire  [31:0] bdata_a, bdata_c;
  wire  [7:0]  bdata_b;

  logic [31:0] mem [3][256];
  bit          low_read_c = 1'b0;
  int          checks = 0;
  int          errors = 0;

  fib_result_checker #(
    .DATA_W(32), .ADDR_W(8), .START_IDX(3), .NUM_TERMS(10), .RUN_CYCLES(200),
    .SEED_MODE(0), .SEED0(1), .SEED1(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .halt_i(halt_v[0]),
    .rd_en_o(rd_en_v[0]), .rd_addr_o(addr_v[0]), .rd_data_i(rd_data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(tmo_v[0]),
    .mismatch_cnt(cnt_a), .first_bad_idx(bidx_v[0]), .first_bad_data(bdata_a)
  );

  fib_result_checker #(
    .DATA_W(8), .ADDR_W(8), .START_IDX(3), .NUM_TERMS(1), .RUN_CYCLES(20),
    .SEED_MODE(0), .SEED0(1), .SEED1(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .halt_i(halt_v[1]),
    .rd_en_o(rd_en_v[1]), .rd_addr_o(addr_v[1]), .rd_data_i(rd_data_v[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(tmo_v[1]),
    .mismatch_cnt(cnt_b), .first_bad_idx(bidx_v[1]), .first_bad_data(bdata_b)
  );

  fib_result_checker #(
    .DATA_W(32), .ADDR_W(8), .START_IDX(3), .NUM_TERMS(10), .RUN_CYCLES(200),
    .SEED_MODE(1), .SEED0(1), .SEED1(1)
  ) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .halt_i(halt_v[2]),
    .rd_en_o(rd_en_v[2]), .rd_addr_o(addr_v[2]), .rd_data_i(rd_data_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .timeout(tmo_v[2]),
    .mismatch_cnt(cnt_c), .first_bad_idx(bidx_v[2]), .first_bad_data(bdata_c)
  );

  // Synchronous-read memories, one per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (rd_en_v[i]) rd_data_v[i] <= mem[i][addr_v[i]];
    if (rd_en_v[2] && addr_v[2] < 8'd3) low_read_c <= 1'b1;
  end

  function automatic int nterms(input int i);
    return (i == 1) ? 1 : 10;
  endfunction
  function automatic int rcyc(input int i);
    return (i == 1) ? 20 : 200;
  endfunction
  function automatic logic [31:0] mask_of(input int i);
    return (i == 1) ? 32'h0000_00ff : 32'hffff_ffff;
  endfunction
  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return {28'b0, cnt_a};
      1:       return {31'b0, cnt_b};
      default: return {28'b0, cnt_c};
    endcase
  endfunction
  function automatic logic [31:0] bdata_of(input int i);
    case (i)
      0:       return bdata_a;
      1:       return {24'b0, bdata_b};
      default: return bdata_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory words 1..12 hold a correct sequence seeded with s0, s1.
  task automatic fill_fib(input int i, input logic [31:0] s0, input logic [31:0] s1);
    logic [31:0] m;
    m = mask_of(i);
    for (int w = 0; w < 256; w++) mem[i][w] = '0;
    mem[i][1] = s0 & m;
    mem[i][2] = s1 & m;
    for (int w = 3; w <= 12; w++) mem[i][w] = (mem[i][w-2] + mem[i][w-1]) & m;
  endtask

  // Expected outcome: walk the sequence from the seeds, compare with memory.
  task automatic model(input int i, output int cnt, output logic [31:0] bidx,
                       output logic [31:0] bdata);
    logic [31:0] a, b, s, m, w;
    m = mask_of(i);
    cnt = 0; bidx = '0; bdata = '0;
    if (i == 2) begin
      a = 1; b = 1;
    end else begin
      a = mem[i][1] & m; b = mem[i][2] & m;
    end
    for (int k = 0; k < nterms(i); k++) begin
      s = (a + b) & m;
      w = mem[i][3+k] & m;
      if (w !== s) begin
        if (cnt == 0) begin
          bidx  = 32'(3 + k);
          bdata = w;
        end
        cnt++;
      end
      a = b;
      b = s;
    end
  endtask

  task automatic check_zero(input int i, input string tag);
    chk({tag, " done"},   32'(done_v[i]),  0);
    chk({tag, " busy"},   32'(busy_v[i]),  0);
    chk({tag, " pass"},   32'(pass_v[i]),  0);
    chk({tag, " tmo"},    32'(tmo_v[i]),   0);
    chk({tag, " rd_en"},  32'(rd_en_v[i]), 0);
    chk({tag, " addr"},   32'(addr_v[i]),  0);
    chk({tag, " cnt"},    cnt_of(i),       0);
    chk({tag, " bidx"},   32'(bidx_v[i]),  0);
    chk({tag, " bdata"},  bdata_of(i),     0);
  endtask

  // One check run: halt_at < 0 means halt never rises; restart_at pulses start mid-run.
  task automatic run(input int i, input int halt_at, input int restart_at, input string tag);
    int cyc, t_rd, t_done, ecnt, exp_rd;
    logic [31:0] eidx, edata;
    bit halted;
    model(i, ecnt, eidx, edata);
    halted = (halt_at >= 0) && (halt_at < rcyc(i));
    exp_rd = halted ? halt_at + 1 : rcyc(i);
    if (i == 2) exp_rd = halted ? halt_at + 1 : rcyc(i);
    @(negedge clk); start_v[i] = 1'b1;
    @(negedge clk); start_v[i] = 1'b0;
    chk({tag, " busy after start"}, 32'(busy_v[i]), 1);
    cyc = 0; t_rd = -1; t_done = -1;
    while (t_done < 0 && cyc < 1000) begin
      halt_v[i]  = (halt_at >= 0) && (cyc >= halt_at);
      start_v[i] = (cyc == restart_at);
      @(negedge clk);
      cyc++;
      if (rd_en_v[i] && t_rd < 0) t_rd = cyc;
      if (done_v[i]) t_done = cyc;
    end
    halt_v[i] = 1'b0; start_v[i] = 1'b0;
    chk({tag, " done reached"}, 32'(t_done >= 0), 1);
    chk({tag, " first read cycle"}, t_rd, exp_rd);
    chk({tag, " done latency"}, t_done - t_rd, nterms(i) + ((i == 2) ? 1 : 3));
    chk({tag, " busy at done"}, 32'(busy_v[i]), 0);
    chk({tag, " pass"}, 32'(pass_v[i]), 32'(ecnt == 0));
    chk({tag, " timeout"}, 32'(tmo_v[i]), 32'(!halted));
    chk({tag, " mismatch_cnt"}, cnt_of(i), ecnt);
    chk({tag, " first_bad_idx"}, 32'(bidx_v[i]), eidx);
    chk({tag, " first_bad_data"}, bdata_of(i), edata);
  endtask

  initial begin
    int cyc, nbad, h;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      halt_v[i]  = 1'b0;
      fill_fib(i, 1, 1);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero(0, "reset a");
    check_zero(1, "reset b");
    check_zero(2, "reset c");

    // Default window, correct memory, halt at cycle 50.
    fill_fib(0, 1, 1);
    run(0, 50, -1, "a_base");
    // Single corrupted word.
    mem[0][7] = 14;
    run(0, 50, -1, "a_bad7");
    chk("a_bad7 idx is 7", 32'(bidx_v[0]), 7);
    chk("a_bad7 data is 14", bdata_of(0), 14);
    // Halt already high at RUN entry.
    fill_fib(0, 1, 1);
    run(0, 0, -1, "a_halt_early");

    // 8-bit wrap with timeout, then a halted run.
    fill_fib(1, 144, 233);
    run(1, -1, -1, "b_wrap_timeout");
    chk("b_wrap pass", 32'(pass_v[1]), 1);
    run(1, 4, -1, "b_halt");
    mem[1][3] = 8'd120;
    run(1, 2, -1, "b_bad");

    // Fixed seeds: memory seeds deliberately wrong and must not be read.
    fill_fib(2, 1, 1);
    mem[2][1] = 99;
    mem[2][2] = 77;
    run(2, 5, -1, "c_fixed");
    chk("c no seed reads", 32'(low_read_c), 0);
    mem[2][5] = mem[2][5] ^ 32'h100;
    mem[2][9] = 0;
    run(2, 2, -1, "c_bad");

    // Random seeds, corruptions and halt times.
    repeat (6) begin
      fill_fib(0, $urandom, $urandom);
      nbad = $urandom_range(0, 3);
      repeat (nbad) begin
        h = $urandom_range(1, 12);
        mem[0][h] = mem[0][h] ^ ($urandom | 32'h1);
      end
      run(0, $urandom_range(0, 80), -1, "a_rand");
    end
    repeat (4) begin
      fill_fib(1, $urandom, $urandom);
      if ($urandom_range(0, 1) == 0) mem[1][$urandom_range(1, 3)] = $urandom_range(0, 255);
      h = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 17));
      run(1, h, -1, "b_rand");
    end

    // Reset mid-scan discards a partial result.
    fill_fib(0, 1, 1);
    mem[0][3] = 0;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; halt_v[0] = 1'b1;
    cyc = 0;
    while (!(rd_en_v[0] && addr_v[0] == 8'd8) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    halt_v[0] = 1'b0;
    chk("rst scan reached", 32'(cyc < 100), 1);
    chk("rst partial cnt", cnt_of(0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero(0, "mid-scan reset a");
    fill_fib(0, 1, 1);
    run(0, 10, 5, "a_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
